// File: rtl/fabric_ff_bank.sv
// Configurable flip-flop bank. A serial configuration chain assigns each flip-flop
// a mode (bypass, DFF, enabled DFF, toggle) and a set-enable bit.
module fabric_ff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             config_enable,
    input  logic             ccff_head,
    output logic             ccff_tail,
    input  logic [WIDTH-1:0] ff_D,
    input  logic [WIDTH-1:0] ff_E,
    output logic [WIDTH-1:0] ff_Q,
    output logic             cfg_valid
);

    localparam int CFG_BITS = 3 * WIDTH;
    localparam int CNT_RAW  = $clog2(CFG_BITS + 1);
    localparam int CNT_W    = (CNT_RAW < 6) ? 6 : CNT_RAW;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS);

    logic [CFG_BITS-1:0] cfg;
    logic [CNT_W-1:0]    count;
    logic [WIDTH-1:0]    q;
    logic [WIDTH-1:0]    q_next;

    assign cfg_valid = (count == CNT_MAX);
    assign ccff_tail = cfg[CFG_BITS-1];

    // Per-bit slice of cfg is {set_en, mode[1:0]}; set_en wins over the mode update.
    always_comb begin
        q_next = q;
        for (int i = 0; i < WIDTH; i++) begin
            if (set && cfg[3*i+2]) begin
                q_next[i] = 1'b1;
            end else begin
                case (cfg[3*i +: 2])
                    2'b01:   q_next[i] = ff_D[i];
                    2'b10:   if (ff_E[i]) q_next[i] = ff_D[i];
                    2'b11:   q_next[i] = q[i] ^ ff_D[i];
                    default: q_next[i] = q[i];
                endcase
            end
        end
    end

    always_comb begin
        ff_Q = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!cfg_valid)
                ff_Q[i] = 1'b0;
            else if (cfg[3*i +: 2] == 2'b00)
                ff_Q[i] = ff_D[i];
            else
                ff_Q[i] = q[i];
        end
    end

    // Shifting freezes the bank; the counter saturates so over-shifting keeps cfg_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg   <= '0;
            count <= '0;
            q     <= '0;
        end else if (config_enable) begin
            cfg <= {cfg[CFG_BITS-2:0], ccff_head};
            if (count != CNT_MAX)
                count <= count + CNT_W'(1);
        end else if (cfg_valid) begin
            q <= q_next;
        end
    end

endmodule
